// File: rtl/game_flow_ctrl_pkg.sv
// Shared encodings and constants for the lane-runner game sequencer.
// State codes, PS2 scan codes and lane geometry.
package game_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_PLAY    = 3'b001,
    ST_PAUSE   = 3'b010,
    ST_OVER    = 3'b011,
    ST_RESPAWN = 3'b100
  } state_t;

  localparam logic [8:0] KEY_START = 9'h05A;
  localparam logic [8:0] KEY_PAUSE = 9'h04D;
  localparam logic [8:0] KEY_LEFT  = 9'h012;
  localparam logic [8:0] KEY_RIGHT = 9'h059;

  localparam int LANE_STEP     = 136;
  localparam int LANE_MAX      = 544;
  localparam int X_START       = 272;
  localparam int LIVES_INIT    = 3;
  localparam int RESPAWN_TICKS = 8;

endpackage

// File: rtl/game_flow_ctrl_bcd3_sat_inc.sv
// Three-digit BCD incrementer (add 0..2), saturating at 999.
// Purely combinational; carries ripple ones -> tens -> hundreds.
module bcd3_sat_inc (
  input  logic [11:0] value,
  input  logic [1:0]  inc,
  output logic [11:0] sum
);

  logic [4:0] ones;
  logic [4:0] tens;
  logic [4:0] hund;
  logic       c0;
  logic       c1;

  always_comb begin
    ones = {1'b0, value[3:0]} + {3'b000, inc};
    c0   = (ones > 5'd9);
    if (c0) ones = ones - 5'd10;

    tens = {1'b0, value[7:4]} + {4'b0000, c0};
    c1   = (tens > 5'd9);
    if (c1) tens = tens - 5'd10;

    hund = {1'b0, value[11:8]} + {4'b0000, c1};

    if (hund > 5'd9) sum = 12'h999;
    else             sum = {hund[3:0], tens[3:0], ones[3:0]};
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: owns state, lane position, lives and BCD score.
// Driven by PS2 make events, frame ticks and hit/coin pulses.
module game_flow_ctrl #(
  parameter int LANE_STEP     = game_flow_ctrl_pkg::LANE_STEP,
  parameter int LANE_MAX      = game_flow_ctrl_pkg::LANE_MAX,
  parameter int X_START       = game_flow_ctrl_pkg::X_START,
  parameter int LIVES_INIT    = game_flow_ctrl_pkg::LIVES_INIT,
  parameter int RESPAWN_TICKS = game_flow_ctrl_pkg::RESPAWN_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic        key_make,
  input  logic [8:0]  key_code,
  input  logic        tick,
  input  logic        hit,
  input  logic        coin,
  output logic [2:0]  state,
  output logic [9:0]  x,
  output logic [1:0]  lives,
  output logic [11:0] point
);

  import game_flow_ctrl_pkg::*;

  localparam int CW =
    (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

  state_t      st;
  state_t      st_n;
  logic [9:0]  x_n;
  logic [1:0]  lives_n;
  logic [11:0] point_n;
  logic [11:0] point_inc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]  inc;

  logic make;
  logic k_start;
  logic k_pause;
  logic k_left;
  logic k_right;
  logic can_left;
  logic can_right;

  assign make    = key_valid & key_make;
  assign k_start = make & (key_code == KEY_START);
  assign k_pause = make & (key_code == KEY_PAUSE);
  assign k_left  = make & (key_code == KEY_LEFT);
  assign k_right = make & (key_code == KEY_RIGHT);

  assign can_left  = (x >= 10'(LANE_STEP));
  assign can_right =
    ({1'b0, x} + 11'(LANE_STEP)) <= 11'(LANE_MAX);

  assign inc = {1'b0, tick} + {1'b0, coin};

  bcd3_sat_inc u_inc (
    .value (point),
    .inc   (inc),
    .sum   (point_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ST_IDLE;
      x     <= 10'(X_START);
      lives <= 2'd0;
      point <= 12'h000;
      cnt   <= '0;
    end else begin
      st    <= st_n;
      x     <= x_n;
      lives <= lives_n;
      point <= point_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    st_n    = st;
    x_n     = x;
    lives_n = lives;
    point_n = point;
    cnt_n   = cnt;
    case (st)
      ST_IDLE, ST_OVER: begin
        if (k_start) begin
          st_n    = ST_PLAY;
          lives_n = 2'(LIVES_INIT);
          point_n = 12'h000;
          x_n     = 10'(X_START);
        end
      end
      ST_PLAY: begin
        point_n = point_inc;
        // A hit pre-empts any key seen on the same edge.
        if (hit) begin
          lives_n = lives - 2'd1;
          if (lives == 2'd1) begin
            st_n = ST_OVER;
          end else begin
            st_n  = ST_RESPAWN;
            x_n   = 10'(X_START);
            cnt_n = '0;
          end
        end else begin
          unique case (1'b1)
            k_left:  if (can_left)  x_n = x - 10'(LANE_STEP);
            k_right: if (can_right) x_n = x + 10'(LANE_STEP);
            k_pause: st_n = ST_PAUSE;
            default: ;
          endcase
        end
      end
      ST_PAUSE: begin
        if (k_pause) st_n = ST_PLAY;
      end
      ST_RESPAWN: begin
        if (tick) begin
          if (cnt == CW'(RESPAWN_TICKS - 1)) begin
            st_n  = ST_PLAY;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed scenarios then random play
// against a lane/integer-score reference model.
module tb_game_flow_ctrl;

  localparam logic [8:0] K_START = 9'h05A;
  localparam logic [8:0] K_PAUSE = 9'h04D;
  localparam logic [8:0] K_LEFT  = 9'h012;
  localparam logic [8:0] K_RIGHT = 9'h059;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_make = 1'b0;
  logic [8:0]  key_code = '0;
  logic        tick = 1'b0;
  logic        hit = 1'b0;
  logic        coin = 1'b0;
  logic [2:0]  state;
  logic [9:0]  x;
  logic [1:0]  lives;
  logic [11:0] point;

  game_flow_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_make  (key_make),
    .key_code  (key_code),
    .tick      (tick),
    .hit       (hit),
    .coin      (coin),
    .state     (state),
    .x         (x),
    .lives     (lives),
    .point     (point)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [9:0]  x;
    logic [1:0]  lv;
    logic [11:0] pt;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  // Reference model: states as small ints, lane index 0..4, integer score.
  int m_st, m_lane, m_lives, m_score, m_cnt;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = 3'(m_st);
    e.x  = 10'(m_lane * 136);
    e.lv = 2'(m_lives);
    e.pt = to_bcd(m_score);
    e.id = step_id;
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0; m_lane = 2; m_lives = 0; m_score = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit kv, input bit km,
                            input logic [8:0] code,
                            input bit t, input bit h, input bit c);
    bit mk;
    mk = kv && km;
    case (m_st)
      0, 3: if (mk && code == K_START) begin
        m_st = 1; m_lives = 3; m_score = 0; m_lane = 2;
      end
      1: begin
        m_score = m_score + int'(t) + int'(c);
        if (m_score > 999) m_score = 999;
        if (h) begin
          if (m_lives == 1) begin
            m_lives = 0; m_st = 3;
          end else begin
            m_lives = m_lives - 1; m_st = 4; m_lane = 2; m_cnt = 0;
          end
        end else if (mk) begin
          if (code == K_LEFT && m_lane > 0) m_lane--;
          else if (code == K_RIGHT && m_lane < 4) m_lane++;
          else if (code == K_PAUSE) m_st = 2;
        end
      end
      2: if (mk && code == K_PAUSE) m_st = 1;
      4: if (t) begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_st = 1; m_cnt = 0;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic step(input bit kv, input bit km, input logic [8:0] code,
                      input bit t, input bit h, input bit c);
    @(negedge clk);
    key_valid = kv; key_make = km; key_code = code;
    tick = t; hit = h; coin = c;
    step_id++;
    model_step(kv, km, code, t, h, c);
    q.push_back(model_out());
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic compare(input string name, input exp_t e);
    n_checks++;
    if (state === e.st && x === e.x && lives === e.lv && point === e.pt)
      n_pass++;
    else
      $display("FAIL %s step %0d: got st=%0d x=%0d lives=%0d point=%h, expected st=%0d x=%0d lives=%0d point=%h",
               name, e.id, state, x, lives, point, e.st, e.x, e.lv, e.pt);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      compare("scoreboard", e);
    end
  end

  task automatic drain();
    int guard;
    idle_step();
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_now(input string name);
    compare(name, model_out());
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_values");
    @(negedge clk);
    rst = 1'b0;

    // Break alone, then make, of START.
    step(1, 0, K_START, 0, 0, 0);
    step(1, 1, K_START, 0, 0, 0);
    repeat (3) step(1, 1, K_RIGHT, 0, 0, 0);
    repeat (5) step(1, 1, K_LEFT, 0, 0, 0);
    repeat (2) step(1, 1, K_RIGHT, 0, 0, 0);

    // Score carries and saturation.
    repeat (49) step(0, 0, 9'h000, 1, 0, 1);
    step(0, 0, 9'h000, 1, 0, 1);
    repeat (450) step(0, 0, 9'h000, 1, 0, 1);
    step(0, 0, 9'h000, 1, 0, 0);
    step(0, 0, 9'h000, 0, 0, 1);

    // Hit with RIGHT, respawn, hits and coins ignored there.
    step(1, 1, K_RIGHT, 0, 1, 0);
    step(0, 0, 9'h000, 0, 1, 1);
    step(1, 1, K_PAUSE, 0, 0, 0);
    repeat (7) step(0, 0, 9'h000, 1, 0, 0);
    step(1, 1, K_LEFT, 0, 0, 0);
    step(0, 0, 9'h000, 1, 0, 0);
    step(1, 1, K_LEFT, 0, 0, 0);

    // Pause freezes everything until the next PAUSE make.
    step(1, 1, K_PAUSE, 0, 0, 0);
    step(1, 1, K_RIGHT, 1, 1, 1);
    step(1, 1, K_START, 1, 0, 0);
    step(1, 0, K_PAUSE, 0, 0, 0);
    step(1, 1, K_PAUSE, 0, 0, 0);

    // Last life lost, then restart from OVER.
    step(0, 0, 9'h000, 0, 1, 0);
    repeat (8) step(0, 0, 9'h000, 1, 0, 0);
    step(0, 0, 9'h000, 1, 1, 1);
    step(0, 0, 9'h000, 1, 0, 1);
    step(1, 1, K_START, 0, 0, 0);
    step(1, 1, K_RIGHT, 1, 0, 0);
    drain();

    // Asynchronous reset in the middle of PLAY.
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_now("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      bit kv, km, t, h, c;
      logic [8:0] code;
      int sel;
      kv  = ($urandom_range(0, 9) < 3);
      km  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: code = K_START;
        1: code = K_PAUSE;
        2: code = K_LEFT;
        3: code = K_RIGHT;
        4: code = K_RIGHT;
        default: code = 9'($urandom);
      endcase
      t = $urandom_range(0, 1);
      c = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 19) == 0);
      step(kv, km, code, t, h, c);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the lane-runner datapath. Consumes PS2 make/break events, frame-tick pulses and collision/coin pulses, and owns the 3-bit game state, the player lane position x, the lives count, and the 3-digit BCD score shown on the seven-segment display. It replaces ad-hoc lane movement logic. It is the single writer of state, x and point.

Parameters:
LANE_STEP, 136, x increment per lane move
LANE_MAX, 544, rightmost legal x (5 lanes: 0..544)
X_START, 272, x after reset, game start and respawn
LIVES_INIT, 3, lives loaded at game start
RESPAWN_TICKS, 8, tick pulses spent in RESPAWN before returning to PLAY

Ports:
clk  in  1  system clock
rst  in  1  reset
key_valid  in  1  one-cycle pulse: new key event on key_code
key_make  in  1  1 = press (make), 0 = release (break); valid with key_valid
key_code  in  9  PS2 scan code, bit 8 = extended (E0) flag
tick  in  1  one-cycle frame/time pulse
hit  in  1  one-cycle collision pulse
coin  in  1  one-cycle coin-collected pulse
state  out  3  IDLE=000, PLAY=001, PAUSE=010, OVER=011, RESPAWN=100
x  out  10  player lane position
lives  out  2  remaining lives
point  out  12  score, 3 BCD digits {hundreds, tens, ones}

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk. Reset values: state=IDLE, x=X_START, lives=0, point=0, respawn counter=0.
- Only make events act (key_valid && key_make). Breaks and all other codes are ignored.
- Key codes: START=0_0101_1010 (Enter), PAUSE=0_0100_1101 (P), LEFT=0_0001_0010 (L-shift), RIGHT=0_0101_1001 (R-shift).
- All outputs are registered. Each event takes effect on the clock edge of its pulse; the output changes the next cycle.
- IDLE: START -> PLAY; same edge loads lives=LIVES_INIT, point=0, x=X_START. Other inputs are ignored.
- PLAY:
  - LEFT: x -= LANE_STEP if x >= LANE_STEP, else hold.
  - RIGHT: x += LANE_STEP if x + LANE_STEP <= LANE_MAX, else hold.
  - PAUSE -> PAUSE.
  - hit: lives -= 1. If the old lives == 1 -> OVER; else -> RESPAWN with x=X_START and the counter cleared.
  - Score increments by tick + coin (0, 1 or 2 per cycle), in BCD, saturating at 999.
- PLAY priority in one cycle: hit > key. When hit is present, a simultaneous key action is dropped. Score is still added on that edge.
- PAUSE: PAUSE key -> PLAY. tick, coin, hit and moves are ignored. START is ignored.
- RESPAWN:
  - Counter increments on tick. When the counter reaches RESPAWN_TICKS-1 and tick is high -> PLAY.
  - hit, coin and moves are ignored; no score from tick.
  - PAUSE key is ignored.
- OVER: START -> PLAY with the same loads as from IDLE. point holds the final score until restart.
- Unused state encodings (101..111) -> IDLE on the next edge.
- rst asserted mid-game returns to the reset values asynchronously, regardless of state.
- BCD rule: each digit stays in 0..9. Carries ripple ones -> tens -> hundreds. If the sum exceeds 999, the result is 999.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE..ST_RESPAWN);
  - scan-code constants (KEY_START, KEY_PAUSE, KEY_LEFT, KEY_RIGHT);
  - the lane constants.
- One sub-module: bcd3_sat_inc.
  - Inputs: 12-bit BCD value, 2-bit increment (0..2).
  - Output: saturated 12-bit BCD.
  - Purely combinational; instantiated once.

Test Plan:
- Reset, then START make -> state=001, lives=3, x=272, point=000. START break alone -> no change.
- In PLAY: RIGHT, RIGHT, RIGHT -> x=408, 544, 544 (clamped). Then 5x LEFT -> x=408, 272, 136, 0, 0.
- point=0x098, tick and coin on the same cycle -> point=0x100. From point=0x999, tick -> point stays 0x999.
- lives=3, hit coincident with RIGHT -> lives=2, state=100, x=272 (move dropped). Then 8 ticks -> state=001 on the 8th tick's edge. A hit during RESPAWN -> lives unchanged.
- PAUSE make in PLAY -> 010. tick/coin/hit ignored while paused. PAUSE again -> 001.
- lives=1, hit -> state=011, lives=0, point frozen. START -> 001, lives=3, point=000. Assert rst mid-PLAY -> state=000, x=272 immediately.
